tag_arbiter: RTL and testbench

Collects event strobes from N already-synchronized tag inputs, one `sync` per channel upstream, and timestamps each rising edge against a free-running counter. It queues one pending event per channel and serializes them onto a single valid/ready stream using round-robin arbitration. It sits between the per-channel synchronizers and the tag FIFO/readout logic, and counts events lost to per-channel overrun.

---
 rtl/tag_arbiter_if.sv | 20 ++
 rtl/tag_arbiter.sv | 146 ++++++++++++++
 tb/tb_tag_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_arbiter_if.sv
// tag_arbiter_if: output event stream between the tag arbiter and the tag FIFO/readout.
//   out_valid  event valid (producer)
//   out_ready  consumer ready (consumer)
//   out_ch     channel index of the event (producer)
//   out_ts     timestamp of the event (producer)
// Modports: master = arbiter side, slave = consumer side.
interface tag_arbiter_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned TS_W = 32
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_ch;
  logic [TS_W-1:0] out_ts;

  modport master (output out_valid, output out_ch, output out_ts, input out_ready);
  modport slave  (input out_valid, input out_ch, input out_ts, output out_ready);
endinterface

// File: rtl/tag_arbiter.sv
// tag_arbiter: timestamps rising edges on N_CH synchronized event inputs, keeps one pending
// event per channel, counts overruns, and serializes pending events onto a valid/ready stream
// with round-robin arbitration.
//   clk     clock, rising edge
//   rstn    synchronous active-low reset
//   ev_i    synchronized event levels (rising edge = event)
//   en_i    per-channel enable for new edges
//   clr_i   one-cycle pulse clearing pending flags and overflow counters
//   out_if  output stream (out_valid/out_ready/out_ch/out_ts)
//   pend_o  per-channel pending flags
//   ovf_o   per-channel saturating overflow counters, channel k at [k*CNT_W +: CNT_W]
module tag_arbiter #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned TS_W  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_CH-1:0]         ev_i,
  input  logic [N_CH-1:0]         en_i,
  input  logic                    clr_i,
  tag_arbiter_if.master           out_if,
  output logic [N_CH-1:0]         pend_o,
  output logic [N_CH*CNT_W-1:0]   ovf_o
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // Output stage states
  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [N_CH-1:0]  ev_q, ev_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [TS_W-1:0]  cap_ts_q [N_CH];
  logic [TS_W-1:0]  cap_ts_d [N_CH];
  logic [CNT_W-1:0] ovf_q [N_CH];
  logic [CNT_W-1:0] ovf_d [N_CH];
  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [TS_W-1:0]  out_ts_q, out_ts_d;

  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  loaded;
  logic [CH_W-1:0]  gnt;
  logic             gnt_found;
  logic             load;

  assign ts_d = ts_q + 1'b1;
  assign ev_d = ev_i;
  assign rise = ev_i & ~ev_q & en_i;

  // A clear cycle never loads, so a cleared event cannot slip onto the output.
  assign load   = (|pend_q) & ((state_q == StEmpty) | out_if.out_ready) & ~clr_i;
  assign loaded = load ? (N_CH'(1) << gnt) : '0;

  // Round-robin: first pending channel after the last grant.
  always_comb begin
    logic [CH_W-1:0] idx;
    gnt       = '0;
    gnt_found = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = CH_W'((32'(ptr_q) + i) % N_CH);
      if (!gnt_found && pend_q[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
      end
    end
  end

  // Per-channel capture; a channel loaded this cycle may accept a new edge immediately.
  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      pend_d[k]   = pend_q[k];
      cap_ts_d[k] = cap_ts_q[k];
      ovf_d[k]    = ovf_q[k];
      if (clr_i) begin
        pend_d[k] = 1'b0;
        ovf_d[k]  = '0;
      end else if (rise[k] && (!pend_q[k] || loaded[k])) begin
        pend_d[k]   = 1'b1;
        cap_ts_d[k] = ts_q;
      end else if (rise[k]) begin
        if (ovf_q[k] != '1) ovf_d[k] = ovf_q[k] + 1'b1;
      end else if (loaded[k]) begin
        pend_d[k] = 1'b0;
      end
    end
  end

  // Output stage
  always_comb begin
    state_d  = state_q;
    out_ch_d = out_ch_q;
    out_ts_d = out_ts_q;
    ptr_d    = ptr_q;
    if (load) begin
      state_d  = StFull;
      out_ch_d = gnt;
      out_ts_d = cap_ts_q[gnt];
      ptr_d    = gnt;
    end else if ((state_q == StFull) && out_if.out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StEmpty;
      ts_q     <= '0;
      ev_q     <= '1;  // a level already high at reset release is not an event
      pend_q   <= '0;
      ptr_q    <= CH_W'(N_CH - 1);
      out_ch_q <= '0;
      out_ts_q <= '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
        cap_ts_q[k] <= '0;
        ovf_q[k]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      ev_q     <= ev_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      out_ch_q <= out_ch_d;
      out_ts_q <= out_ts_d;
      for (int unsigned k = 0; k < N_CH; k++) begin
        cap_ts_q[k] <= cap_ts_d[k];
        ovf_q[k]    <= ovf_d[k];
      end
    end
  end

  assign out_if.out_valid = (state_q == StFull);
  assign out_if.out_ch    = out_ch_q;
  assign out_if.out_ts    = out_ts_q;
  assign pend_o           = pend_q;

  always_comb begin
    ovf_o = '0;
    for (int unsigned k = 0; k < N_CH; k++) ovf_o[k*CNT_W +: CNT_W] = ovf_q[k];
  end
endmodule

// File: tb/tb_tag_arbiter.sv
// Bench for tag_arbiter: directed sequences, a table of vectors for the simultaneous-event case,
// and randomized stimulus checked every cycle against a behavioural model.
module tb_tag_arbiter;
  localparam int N = 4;
  localparam int TSW = 32;
  localparam int CW = 8;
  localparam int OVF_MAX = (1 << CW) - 1;
  localparam longint TS_MOD = 64'd1 << TSW;

  logic clk = 1'b0;
  logic rstn;
  logic [N-1:0] ev, en;
  logic clr, ready;
  logic [N-1:0] pend_o;
  logic [N*CW-1:0] ovf_o;

  tag_arbiter_if #(.N_CH(N), .TS_W(TSW)) bus ();
  assign bus.out_ready = ready;

  tag_arbiter #(.N_CH(N), .TS_W(TSW), .CNT_W(CW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .ev_i   (ev),
    .en_i   (en),
    .clr_i  (clr),
    .out_if (bus),
    .pend_o (pend_o),
    .ovf_o  (ovf_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: one pending slot per channel, one output slot, last grant index.
  bit     m_pend [N];
  longint m_cap  [N];
  int     m_ovf  [N];
  bit     m_prev [N];
  bit     m_valid;
  int     m_ch;
  longint m_ots;
  int     m_last;
  longint m_ts;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (model ts %0d)", name, act, exp, m_ts);
    end
  endtask

  task automatic model_step();
    bit do_load;
    bit any;
    int g;
    if (!rstn) begin
      for (int k = 0; k < N; k++) begin
        m_pend[k] = 0; m_cap[k] = 0; m_ovf[k] = 0; m_prev[k] = 1;
      end
      m_valid = 0; m_ch = 0; m_ots = 0; m_last = N - 1; m_ts = 0;
      return;
    end
    any = 0;
    for (int k = 0; k < N; k++) if (m_pend[k]) any = 1;
    do_load = any && !clr && (!m_valid || ready);
    g = -1;
    if (do_load) begin
      for (int j = 1; j <= N; j++) begin
        int c;
        c = (m_last + j) % N;
        if (g < 0 && m_pend[c]) g = c;
      end
      m_valid = 1; m_ch = g; m_ots = m_cap[g]; m_last = g; m_pend[g] = 0;
    end else if (m_valid && ready) begin
      m_valid = 0;
    end
    for (int k = 0; k < N; k++) begin
      bit r;
      r = ev[k] && !m_prev[k] && en[k];
      if (clr) begin
        m_pend[k] = 0; m_ovf[k] = 0;
      end else if (r) begin
        if (m_pend[k]) m_ovf[k] = (m_ovf[k] < OVF_MAX) ? m_ovf[k] + 1 : OVF_MAX;
        else begin m_pend[k] = 1; m_cap[k] = m_ts; end
      end
      m_prev[k] = ev[k];
    end
    m_ts = (m_ts + 1) % TS_MOD;
  endtask

  task automatic check_model();
    logic [N-1:0] ep;
    logic [N*CW-1:0] eo;
    for (int k = 0; k < N; k++) begin
      ep[k] = m_pend[k];
      eo[k*CW +: CW] = CW'(m_ovf[k]);
    end
    chk("model_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("model_ch", 64'(bus.out_ch), 64'(m_ch));
    chk("model_ts", 64'(bus.out_ts), 64'(m_ots));
    chk("model_pend", 64'(pend_o), 64'(ep));
    chk("model_ovf", 64'(ovf_o), 64'(eo));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic run_to(input longint t);
    int guard;
    guard = 0;
    while (m_ts != t && guard < 2000) begin step(); guard++; end
    chk("run_to_reached", 64'(m_ts), 64'(t));
  endtask

  task automatic pulse(input logic [N-1:0] m);
    ev = m; step();
    ev = '0; step();
  endtask

  typedef struct {
    logic [N-1:0] ev;
    logic         exp_valid;
    int           exp_ch;
    longint       exp_ts;
    logic [N-1:0] exp_pend;
  } vec_t;

  vec_t tbl[11];
  longint t0;

  initial begin
    tbl[0]  = '{4'b1111, 1'b0, 0, 0,  4'b1111};
    tbl[1]  = '{4'b1111, 1'b1, 0, 50, 4'b1110};
    tbl[2]  = '{4'b1111, 1'b1, 1, 50, 4'b1100};
    tbl[3]  = '{4'b1111, 1'b1, 2, 50, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 3, 50, 4'b0000};
    tbl[5]  = '{4'b1111, 1'b0, 0, 0,  4'b0000};
    tbl[6]  = '{4'b1100, 1'b0, 0, 0,  4'b0000};
    tbl[7]  = '{4'b1111, 1'b0, 0, 0,  4'b0011};
    tbl[8]  = '{4'b1111, 1'b1, 0, 57, 4'b0010};
    tbl[9]  = '{4'b1111, 1'b1, 1, 57, 4'b0000};
    tbl[10] = '{4'b1111, 1'b0, 0, 0,  4'b0000};

    // Reset with all levels high, then release with them still high.
    rstn = 0; ev = '1; en = '1; clr = 0; ready = 1;
    repeat (5) step();
    rstn = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("reset_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_pend", 64'(pend_o), 64'd0);
      chk("reset_ovf", 64'(ovf_o), 64'd0);
      chk("reset_ch_ts", {32'(bus.out_ch), bus.out_ts}, 64'd0);
    end

    // Simultaneous edges at ts=50, then channels 0 and 1 again after ptr=3.
    ev = '0;
    run_to(50);
    for (int i = 0; i < 11; i++) begin
      ev = tbl[i].ev;
      step();
      chk("tbl_valid", 64'(bus.out_valid), 64'(tbl[i].exp_valid));
      chk("tbl_pend", 64'(pend_o), 64'(tbl[i].exp_pend));
      if (tbl[i].exp_valid) begin
        chk("tbl_ch", 64'(bus.out_ch), 64'(tbl[i].exp_ch));
        chk("tbl_ts", 64'(bus.out_ts), 64'(tbl[i].exp_ts));
      end
    end

    // Single event on channel 2 sampled at ts=100.
    ev = '0;
    run_to(100);
    ev = 4'b0100; step();
    chk("single_pend", 64'(pend_o), 64'b0100);
    chk("single_not_yet", 64'(bus.out_valid), 64'd0);
    step();
    chk("single_ts_now", 64'(m_ts), 64'd102);
    chk("single_valid", 64'(bus.out_valid), 64'd1);
    chk("single_ch", 64'(bus.out_ch), 64'd2);
    chk("single_ts", 64'(bus.out_ts), 64'd100);
    step();
    chk("single_one_beat", 64'(bus.out_valid), 64'd0);
    ev = '0; step();

    // Backpressure and overflow on channel 1.
    ready = 0;
    t0 = m_ts;
    pulse(4'b0010);
    chk("bp_first_out", {32'(bus.out_valid), bus.out_ts}, {32'd1, 32'(t0)});
    run_to(t0 + 10);
    pulse(4'b0010);
    chk("bp_second_pend", 64'(pend_o), 64'b0010);
    run_to(t0 + 20);
    pulse(4'b0010);
    chk("bp_ovf1", 64'(ovf_o[CW +: CW]), 64'd1);
    chk("bp_hold_ts", 64'(bus.out_ts), 64'(t0));
    ready = 1; step();
    chk("bp_beat2", {32'(bus.out_valid), bus.out_ts}, {32'd1, 32'(t0 + 10)});
    step();
    chk("bp_no_third", 64'(bus.out_valid), 64'd0);

    // Saturation on channel 3, then clear while a beat is held.
    ready = 0;
    pulse(4'b1000);
    pulse(4'b1000);
    for (int i = 0; i < 300; i++) pulse(4'b1000);
    chk("sat_ovf3", 64'(ovf_o[3*CW +: CW]), 64'd255);
    chk("sat_pend", 64'(pend_o), 64'b1000);
    clr = 1; step(); clr = 0;
    chk("clr_ovf", 64'(ovf_o), 64'd0);
    chk("clr_pend", 64'(pend_o), 64'd0);
    chk("clr_keeps_beat", {32'(bus.out_valid), 32'(bus.out_ch)}, {32'd1, 32'd3});
    ready = 1; step();
    chk("clr_beat_taken", 64'(bus.out_valid), 64'd0);

    // Masked edge, and edge coinciding with clear.
    en = 4'b1110;
    ev = 4'b0001; step();
    chk("mask_pend", 64'(pend_o), 64'd0);
    ev = '0; step();
    chk("mask_no_out", 64'(bus.out_valid), 64'd0);
    en = '1;
    ev = 4'b0100; clr = 1; step(); clr = 0;
    chk("clr_edge_pend", 64'(pend_o), 64'd0);
    step();
    chk("clr_edge_no_out", 64'(bus.out_valid), 64'd0);
    ev = '0; step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rstn  = ($urandom_range(0, 299) != 0);
      clr   = ($urandom_range(0, 59) == 0);
      ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 2) == 0) ev[k] = ~ev[k];
        en[k] = ($urandom_range(0, 7) != 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
